// File: rtl/neuron_train_ctrl.sv
// Training sequencer for a single perceptron: buffers labelled samples, then
// replays them epoch by epoch to an external datapath until weights settle.
module neuron_train_ctrl #(
  parameter int DEPTH     = 64,
  parameter int MAX_EPOCH = 100,
  parameter int AW        = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic signed [6:0] load_x1,
  input  logic signed [6:0] load_x2,
  input  logic signed [1:0] load_t,
  input  logic              clear,
  input  logic              start,
  output logic [AW:0]       n_samples,
  output logic              load_full,
  output logic [6:0]        dp_x1,
  output logic [6:0]        dp_x2,
  output logic [1:0]        dp_t,
  output logic              dp_valid,
  input  logic              dp_ready,
  input  logic              dp_ack,
  input  logic              dp_changed,
  output logic              dp_init,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [7:0]        epoch,
  output logic [2:0]        dbg_state
);

  // dp_valid/dp_ready: a sample is transferred on a rising edge where both are
  // high; while dp_valid is high without dp_ready the offered data is frozen.

  typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, EPOCH_END, DONE} state_t;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic signed [6:0] buf_x1 [DEPTH];
  logic signed [6:0] buf_x2 [DEPTH];
  logic signed [1:0] buf_t  [DEPTH];

  logic [AW-1:0] idx, idx_nxt;
  logic [7:0]    epoch_nxt, epoch_inc;
  logic          chg_flag, chg_nxt, conv_nxt;
  logic          load_ok, last_sample;

  assign load_full   = (n_samples == FULL_CNT);
  assign load_ok     = (state == IDLE) && load_en && !start && !clear && !load_full;
  assign last_sample = ({1'b0, idx} == (n_samples - CNT_ONE));
  assign epoch_inc   = (epoch == 8'hFF) ? epoch : epoch + 8'd1;

  assign dp_valid  = (state == ISSUE);
  assign dp_init   = (state == INIT);
  assign done      = (state == DONE);
  assign busy      = (state == INIT) || (state == ISSUE) || (state == WAIT) || (state == EPOCH_END);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    epoch_nxt = epoch;
    chg_nxt   = chg_flag;
    conv_nxt  = converged;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_samples != '0) begin
            state_nxt = INIT;
          end else begin
            state_nxt = DONE;
            conv_nxt  = 1'b0;
            epoch_nxt = 8'd0;
          end
        end
      end
      INIT: begin
        idx_nxt   = '0;
        epoch_nxt = 8'd0;
        chg_nxt   = 1'b0;
        conv_nxt  = 1'b0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (dp_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (dp_ack) begin
          chg_nxt = chg_flag | dp_changed;
          if (last_sample) begin
            state_nxt = EPOCH_END;
          end else begin
            idx_nxt   = idx + AW'(1);
            state_nxt = ISSUE;
          end
        end
      end
      EPOCH_END: begin
        epoch_nxt = epoch_inc;
        if (!chg_flag) begin
          state_nxt = DONE;
          conv_nxt  = 1'b1;
        end else if (epoch_inc == 8'(MAX_EPOCH)) begin
          state_nxt = DONE;
          conv_nxt  = 1'b0;
        end else begin
          idx_nxt   = '0;
          chg_nxt   = 1'b0;
          state_nxt = ISSUE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      epoch     <= 8'd0;
      chg_flag  <= 1'b0;
      converged <= 1'b0;
      n_samples <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      epoch     <= epoch_nxt;
      chg_flag  <= chg_nxt;
      converged <= conv_nxt;
      if ((state == IDLE) && clear) n_samples <= '0;
      else if (load_ok)             n_samples <= n_samples + CNT_ONE;
    end
  end

  // Offer registers reload on every cycle headed into ISSUE; the buffer is
  // frozen while busy, so repeated reloads during a stall keep data stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_x1 <= '0;
      dp_x2 <= '0;
      dp_t  <= '0;
    end else if (state_nxt == ISSUE) begin
      dp_x1 <= buf_x1[idx_nxt];
      dp_x2 <= buf_x2[idx_nxt];
      dp_t  <= buf_t[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) begin
      buf_x1[n_samples[AW-1:0]] <= load_x1;
      buf_x2[n_samples[AW-1:0]] <= load_x2;
      buf_t[n_samples[AW-1:0]]  <= load_t;
    end
  end

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Bench for neuron_train_ctrl: directed sample tables, a datapath responder,
// and scoreboards for offered samples and for done/converged/epoch results.
module tb_neuron_train_ctrl;

  localparam int DEPTH = 8, AW = 3, MAX_EPOCH = 3;

  logic clk, rst_n;
  logic load_en, clear, start, dp_ready, dp_ack, dp_changed;
  logic [6:0] load_x1, load_x2, dp_x1, dp_x2;
  logic [1:0] load_t, dp_t;
  logic [AW:0] n_samples;
  logic load_full, dp_valid, dp_init, busy, done, converged;
  logic [7:0] epoch;
  logic [2:0] dbg_state;

  neuron_train_ctrl #(.DEPTH(DEPTH), .MAX_EPOCH(MAX_EPOCH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_x1(load_x1),
    .load_x2(load_x2), .load_t(load_t), .clear(clear), .start(start),
    .n_samples(n_samples), .load_full(load_full), .dp_x1(dp_x1),
    .dp_x2(dp_x2), .dp_t(dp_t), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .dp_ack(dp_ack), .dp_changed(dp_changed), .dp_init(dp_init),
    .busy(busy), .done(done), .converged(converged), .epoch(epoch),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, init_cnt = 0;
  logic [15:0] exp_q[$];
  logic [8:0]  exp_done_q[$];
  bit chg_mode = 0;
  int stall_left = 0;
  logic [6:0] sx1 [10];
  logic [6:0] sx2 [10];
  logic [1:0] st  [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  // Datapath responder and offer monitor: acks each accepted sample one cycle later.
  initial begin : responder
    logic ack_next;
    logic [15:0] snap, e;
    ack_next = 0; snap = '0;
    dp_ready = 0; dp_ack = 0; dp_changed = 0;
    forever begin
      @(negedge clk);
      dp_ack     = ack_next;
      dp_changed = ack_next ? chg_mode : 1'b0;
      ack_next   = 0;
      if (dp_valid && stall_left > 0) begin
        dp_ready = 0;
        if (stall_left == 5) snap = {dp_x1, dp_x2, dp_t};
        else check("stall_hold", {15'd0, dp_valid, dp_x1, dp_x2, dp_t}, {15'd0, 1'b1, snap});
        if (stall_left == 3) dp_ack = 1;
        stall_left--;
      end else begin
        dp_ready = 1;
        if (dp_valid) begin
          ack_next = 1;
          if (exp_q.size() == 0) flag_fail("offer_unexpected");
          else begin
            e = exp_q.pop_front();
            check("offer_data", {16'd0, dp_x1, dp_x2, dp_t}, {16'd0, e});
          end
        end
      end
    end
  end

  initial begin : done_monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (dp_init) init_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) flag_fail("done_unexpected");
        else begin
          e = exp_done_q.pop_front();
          check("done_result", {23'd0, converged, epoch}, {23'd0, e});
        end
      end
    end
  end

  task automatic load(input int i);
    load_x1 = sx1[i]; load_x2 = sx2[i]; load_t = st[i];
    load_en = 1;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic push_offers(input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) exp_q.push_back({sx1[i], sx2[i], st[i]});
  endtask

  task automatic train(input bit exp_conv, input logic [7:0] exp_ep, input bit nonempty,
                       input bit with_load);
    int c0;
    c0 = done_cnt;
    exp_done_q.push_back({exp_conv, exp_ep});
    if (with_load) begin
      load_x1 = sx1[9]; load_x2 = sx2[9]; load_t = st[9]; load_en = 1;
    end
    start = 1;
    @(negedge clk);
    start = 0; load_en = 0;
    if (nonempty) begin
      check("init_latency", {30'd0, dp_init, busy}, 32'd3);
      @(negedge clk);
      check("valid_latency", {31'd0, dp_valid}, 32'd1);
    end else begin
      check("empty_done", {30'd0, done, busy}, 32'd2);
    end
    for (int k = 0; k < 400 && done_cnt == c0; k++) @(negedge clk);
    if (done_cnt == c0) flag_fail("done_timeout");
    @(negedge clk);
    check("offers_consumed", exp_q.size(), 32'd0);
  endtask

  initial begin : main
    int c0;
    sx1[0] = 7'd10;  sx2[0] = -7'sd3;  st[0] = 2'b01;
    sx1[1] = -7'sd20; sx2[1] = 7'd15;  st[1] = 2'b11;
    sx1[2] = 7'd63;  sx2[2] = -7'sd64; st[2] = 2'b01;
    sx1[3] = 7'd0;   sx2[3] = 7'd5;    st[3] = 2'b11;
    sx1[4] = 7'd1;   sx2[4] = 7'd2;    st[4] = 2'b01;
    sx1[5] = -7'sd1; sx2[5] = -7'sd2;  st[5] = 2'b11;
    sx1[6] = 7'd33;  sx2[6] = 7'd12;   st[6] = 2'b01;
    sx1[7] = -7'sd45; sx2[7] = 7'd20;  st[7] = 2'b11;
    sx1[8] = 7'd7;   sx2[8] = 7'd9;    st[8] = 2'b01;
    sx1[9] = -7'sd7; sx2[9] = -7'sd9;  st[9] = 2'b11;

    rst_n = 0; load_en = 0; clear = 0; start = 0;
    load_x1 = '0; load_x2 = '0; load_t = '0;
    @(negedge clk);
    check("reset_flags", {26'd0, busy, done, dp_valid, dp_init, converged, load_full}, 32'd0);
    check("reset_counts", {21'd0, n_samples, epoch}, 32'd0);
    check("reset_data", {16'd0, dp_x1, dp_x2, dp_t}, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Four samples, no weight changes: one epoch, converged.
    for (int i = 0; i < 4; i++) load(i);
    check("n_after_4", n_samples, 32'd4);
    push_offers(4, 1);
    train(1'b1, 8'd1, 1'b1, 1'b0);
    check("hold_after_done", {15'd0, dp_valid, dp_x1, dp_x2, dp_t},
          {15'd0, 1'b0, sx1[3], sx2[3], st[3]});

    // Ready held low for five cycles with a spurious ack in the middle.
    stall_left = 5;
    push_offers(4, 1);
    train(1'b1, 8'd1, 1'b1, 1'b0);
    check("stall_consumed", stall_left, 32'd0);

    // Start with a concurrent load: load dropped, one init pulse.
    c0 = init_cnt;
    push_offers(4, 1);
    train(1'b1, 8'd1, 1'b1, 1'b1);
    check("init_once", init_cnt - c0, 32'd1);
    check("n_after_start_load", n_samples, 32'd4);

    // Weights always change: stop at the epoch limit.
    chg_mode = 1;
    push_offers(4, MAX_EPOCH);
    train(1'b0, 8'(MAX_EPOCH), 1'b1, 1'b0);
    chg_mode = 0;

    // Overfill, train on the retained samples, clear, then start empty.
    clear = 1; @(negedge clk); clear = 0;
    check("n_after_clear", n_samples, 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) load(i);
    check("full_count", {27'd0, load_full, n_samples}, {27'd0, 1'b1, 4'(DEPTH)});
    push_offers(DEPTH, 1);
    train(1'b1, 8'd1, 1'b1, 1'b0);
    load_x1 = sx1[0]; load_en = 1; clear = 1;
    @(negedge clk);
    load_en = 0; clear = 0;
    check("clear_wins", {27'd0, load_full, n_samples}, 32'd0);
    train(1'b0, 8'd0, 1'b0, 1'b0);

    // Asynchronous reset during a WAIT of the second epoch.
    for (int i = 0; i < 4; i++) load(i);
    chg_mode = 1;
    push_offers(4, 2);
    c0 = done_cnt;
    start = 1; @(negedge clk); start = 0;
    begin : find_wait
      for (int k = 0; k < 200; k++) begin
        if (dbg_state == 3'd3 && epoch == 8'd1) disable find_wait;
        @(negedge clk);
      end
      flag_fail("wait_epoch2_timeout");
    end
    #1 rst_n = 0;
    #1;
    check("async_flags", {26'd0, busy, done, dp_valid, dp_init, converged, load_full}, 32'd0);
    check("async_counts", {18'd0, dbg_state, n_samples, epoch}, 32'd0);
    check("async_data", {16'd0, dp_x1, dp_x2, dp_t}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    chg_mode = 0;
    repeat (6) @(negedge clk);
    check("no_done_after_abort", done_cnt - c0, 32'd0);
    check("n_after_abort", n_samples, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
